// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_ctrl
//  Brief    : Walks an 8:1 mux select through 0..7 and packs the samples
//             into one byte behind a start/done handshake.
//  Revision : 1.0
// ============================================================================
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  localparam logic [3:0] c_settle = 4'(SETTLE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [6:0] r_shadow;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_data;

  // The select lines come straight from the index register, so they can
  // only ever show the index currently being scanned.
  assign {s2, s1, s0} = r_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign data         = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_cnt    <= 4'd0;
      r_shadow <= 7'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state <= ST_WAIT;
            r_idx   <= 3'd0;
            r_cnt   <= c_settle;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            r_state  <= ST_IDLE;
            r_idx    <= 3'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 7'd0;
            r_busy   <= 1'b0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (r_idx != 3'd7) begin
            // Shift in from the top: after seven samples bit k holds index k.
            r_shadow <= {mux_out, r_shadow[6:1]};
            r_idx    <= r_idx + 3'd1;
            r_cnt    <= c_settle;
          end else begin
            r_data  <= {mux_out, r_shadow};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_idx   <= 3'd0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_ctrl
//  Brief    : Self-checking bench for mux_scan_ctrl at SETTLE=0 and SETTLE=3.
//  Revision : 1.0
// ============================================================================
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0] abort = 2'b00;
  logic [7:0] ins [2];

  logic       s0_a, s1_a, s2_a, busy_a, done_a;
  logic       s0_b, s1_b, s2_b, busy_b, done_b;
  logic [7:0] data_a, data_b;
  logic       mux_a, mux_b;

  int checks = 0;
  int errors = 0;
  int done_cnt [2];

  always #5 clk = ~clk;

  // Downstream 8:1 muxes, addressed by the DUT selects.
  assign mux_a = ins[0][{s2_a, s1_a, s0_a}];
  assign mux_b = ins[1][{s2_b, s1_b, s0_b}];

  mux_scan_ctrl #(.SETTLE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .mux_out(mux_a), .s0(s0_a), .s1(s1_a), .s2(s2_a),
    .busy(busy_a), .done(done_a), .data(data_a)
  );

  mux_scan_ctrl #(.SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .mux_out(mux_b), .s0(s0_b), .s1(s1_b), .s2(s2_b),
    .busy(busy_b), .done(done_b), .data(data_b)
  );

  // Scan-level model: a scan lasts 8*(S+1) cycles counted from the start
  // edge; the index is elapsed/(S+1) and a bit is taken on the last cycle
  // of each index slot.
  int         m_s [2] = '{0, 3};
  logic       m_act [2];
  int         m_k [2];
  logic [7:0] m_bits [2];
  logic [7:0] m_data [2];
  logic       m_done [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_k[i] = 0; m_bits[i] = 8'h00;
        m_data[i] = 8'h00; m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (!m_act[i]) begin
          if (start[i] && !abort[i]) begin
            m_act[i] = 1'b1;
            m_k[i] = 0;
          end
        end else if (abort[i]) begin
          m_act[i] = 1'b0;
        end else begin
          if (m_k[i] % (m_s[i] + 1) == m_s[i])
            m_bits[i][m_k[i] / (m_s[i] + 1)] = ins[i][m_k[i] / (m_s[i] + 1)];
          m_k[i]++;
          if (m_k[i] == 8 * (m_s[i] + 1)) begin
            m_act[i] = 1'b0;
            m_data[i] = m_bits[i];
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  logic [2:0] sel_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [7:0] data_w [2];
  assign sel_w[0] = {s2_a, s1_a, s0_a};
  assign sel_w[1] = {s2_b, s1_b, s0_b};
  assign busy_w[0] = busy_a;
  assign busy_w[1] = busy_b;
  assign done_w[0] = done_a;
  assign done_w[1] = done_b;
  assign data_w[0] = data_a;
  assign data_w[1] = data_b;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sel[%0d]", i), int'(sel_w[i]),
            m_act[i] ? m_k[i] / (m_s[i] + 1) : 0);
        chk($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(m_act[i]));
        chk($sformatf("done[%0d]", i), int'(done_w[i]), int'(m_done[i]));
        chk($sformatf("data[%0d]", i), int'(data_w[i]), int'(m_data[i]));
        if (done_w[i]) done_cnt[i]++;
      end
    end
  end

  // Leaves the caller 2 time units after the edge that samples start.
  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(posedge clk); #2;
    start[i] = 1'b0;
  endtask

  task automatic run_scan(input int i, input logic [7:0] v);
    bit seen;
    seen = 1'b0;
    ins[i] = v;
    pulse_start(i);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_w[i]) begin seen = 1'b1; break; end
    end
    chk($sformatf("scan_done_seen[%0d]", i), int'(seen), 1);
    chk($sformatf("scan_data[%0d]", i), int'(data_w[i]), int'(v));
    @(posedge clk); #2;
  endtask

  int base;

  initial begin
    ins[0] = 8'h00; ins[1] = 8'h00;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_data_a", int'(data_a), 8'h00);
    chk("rst_sel_b", int'(sel_w[1]), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #2;

    // Basic scan, SETTLE=0: done exactly in cycle t+9.
    ins[0] = 8'hA5;
    pulse_start(0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("basic_busy_t8", int'(busy_a), 1);
    chk("basic_sel_t8", int'(sel_w[0]), 7);
    chk("basic_done_t8", int'(done_a), 0);
    @(negedge clk);
    chk("basic_done_t9", int'(done_a), 1);
    chk("basic_data_t9", int'(data_a), 8'hA5);
    chk("basic_busy_t9", int'(busy_a), 0);
    @(negedge clk);
    chk("basic_done_t10", int'(done_a), 0);
    @(posedge clk); #2;

    // Settle timing, SETTLE=3: i0 toggles only while the counter runs.
    ins[1] = 8'h3D;
    pulse_start(1);
    repeat (3) @(posedge clk); #2;
    ins[1] = 8'h3C;
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("settle_busy_t32", int'(busy_b), 1);
    chk("settle_done_t32", int'(done_b), 0);
    @(negedge clk);
    chk("settle_done_t33", int'(done_b), 1);
    chk("settle_data_t33", int'(data_b), 8'h3C);
    @(posedge clk); #2;

    // Back-to-back scans with start held high.
    base = done_cnt[0];
    ins[0] = 8'hFF;
    start[0] = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("b2b_first_done", int'(done_a), 1);
    chk("b2b_first_data", int'(data_a), 8'hFF);
    @(posedge clk); #2;
    chk("b2b_no_gap_busy", int'(busy_a), 1);
    ins[0] = 8'h01;
    start[0] = 1'b0;
    repeat (2) @(posedge clk); #2;
    start[0] = 1'b1;
    @(posedge clk); #2;
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("b2b_second_done", int'(done_a), 1);
    chk("b2b_second_data", int'(data_a), 8'h01);
    repeat (5) @(negedge clk);
    chk("b2b_done_count", done_cnt[0] - base, 2);
    chk("b2b_no_queue", int'(busy_a), 0);
    @(posedge clk); #2;

    // Abort mid-scan keeps the previous byte.
    run_scan(0, 8'h5A);
    base = done_cnt[0];
    ins[0] = 8'hFF;
    pulse_start(0);
    repeat (3) @(posedge clk); #2;
    abort[0] = 1'b1;
    @(posedge clk); #2;
    abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_sel", int'(sel_w[0]), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt[0] - base, 0);
    chk("abort_data_kept", int'(data_a), 8'h5A);
    @(posedge clk); #2;
    run_scan(0, 8'hC3);

    // Abort on the final sampling edge, both settle values.
    base = done_cnt[0];
    ins[0] = 8'h0F;
    pulse_start(0);
    repeat (7) @(posedge clk); #2;
    abort[0] = 1'b1;
    @(posedge clk); #2;
    abort[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort7_a_no_done", done_cnt[0] - base, 0);
    chk("abort7_a_data", int'(data_a), 8'hC3);
    @(posedge clk); #2;
    base = done_cnt[1];
    ins[1] = 8'hF0;
    pulse_start(1);
    repeat (31) @(posedge clk); #2;
    abort[1] = 1'b1;
    @(posedge clk); #2;
    abort[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort7_b_no_done", done_cnt[1] - base, 0);
    chk("abort7_b_data", int'(data_b), 8'h3C);
    @(posedge clk); #2;

    // abort together with start in IDLE: nothing starts.
    start[0] = 1'b1; abort[0] = 1'b1;
    @(posedge clk); #2;
    start[0] = 1'b0; abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", int'(busy_a), 0);
    @(posedge clk); #2;

    // Asynchronous reset mid-scan at select 5.
    ins[0] = 8'h77;
    ins[1] = 8'h55;
    start[1] = 1'b1;
    pulse_start(0);
    start[1] = 1'b0;
    repeat (5) @(posedge clk); #2;
    chk("pre_rst_sel", int'(sel_w[0]), 5);
    rst_n = 1'b0;
    #1;
    chk("rst_sel_a", int'(sel_w[0]), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_data_a", int'(data_a), 8'h00);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_data_b", int'(data_b), 8'h00);
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_a", int'(busy_a), 0);
    chk("post_rst_idle_b", int'(busy_b), 0);
    @(posedge clk); #2;
    run_scan(1, 8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
